// File: rtl/note_detector.sv
// ============================================================================
// note_detector : period-counting pitch detector, C5..C7 nearest-note search
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module note_detector #(
  parameter int          PERIODS = 16,
  parameter logic [15:0] HYST    = 16'd256,
  parameter logic [23:0] REF     = 24'd524288,
  parameter logic [23:0] TOL     = 24'd15360
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sample_valid,
  input  logic [15:0] i_sample,
  output logic [4:0]  o_note,
  output logic        o_note_valid,
  output logic        o_note_hit,
  output logic        o_timeout,
  output logic        o_busy
);

  localparam int             XW      = (PERIODS > 1) ? $clog2(PERIODS) : 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(PERIODS - 1);
  localparam logic [11:0]    CNT_MAX = 12'hFFF;
  localparam logic [4:0]     K_LAST  = 5'd24;

  typedef enum logic [1:0] {IDLE, MEASURE, SEARCH, DONE} state_t;

  state_t        state;
  logic [11:0]   cnt;
  logic [XW-1:0] xcnt;
  logic          arm;
  logic          crossing;
  logic [4:0]    k;
  logic [4:0]    best_k;
  logic [23:0]   best_d;

  logic          arm_next;
  logic          crossing_next;
  logic [11:0]   inc;
  logic [23:0]   prod;
  logic [23:0]   diff;

  // Phase increments of the synth oscillator, one per semitone from C5 to C7.
  function automatic logic [11:0] inc_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    inc_lut = 12'd536;
      5'd1:    inc_lut = 12'd568;
      5'd2:    inc_lut = 12'd601;
      5'd3:    inc_lut = 12'd637;
      5'd4:    inc_lut = 12'd675;
      5'd5:    inc_lut = 12'd715;
      5'd6:    inc_lut = 12'd758;
      5'd7:    inc_lut = 12'd803;
      5'd8:    inc_lut = 12'd851;
      5'd9:    inc_lut = 12'd901;
      5'd10:   inc_lut = 12'd955;
      5'd11:   inc_lut = 12'd1011;
      5'd12:   inc_lut = 12'd1072;
      5'd13:   inc_lut = 12'd1135;
      5'd14:   inc_lut = 12'd1203;
      5'd15:   inc_lut = 12'd1274;
      5'd16:   inc_lut = 12'd1350;
      5'd17:   inc_lut = 12'd1430;
      5'd18:   inc_lut = 12'd1515;
      5'd19:   inc_lut = 12'd1606;
      5'd20:   inc_lut = 12'd1701;
      5'd21:   inc_lut = 12'd1802;
      5'd22:   inc_lut = 12'd1909;
      5'd23:   inc_lut = 12'd2023;
      default: inc_lut = 12'd2143;
    endcase
  endfunction

  // Hysteresis: a crossing needs a dip below -HYST before the signal returns to >= 0.
  always_comb begin
    arm_next      = arm;
    crossing_next = 1'b0;
    if (i_sample_valid) begin
      if ($signed(i_sample) < -$signed({1'b0, HYST})) begin
        arm_next = 1'b1;
      end else if (!i_sample[15] && arm) begin
        arm_next      = 1'b0;
        crossing_next = 1'b1;
      end
    end
  end

  always_comb begin
    inc  = inc_lut(k);
    prod = {12'd0, cnt} * {12'd0, inc};
    diff = (prod >= REF) ? (prod - REF) : (REF - prod);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= IDLE;
      cnt          <= 12'd0;
      xcnt         <= '0;
      arm          <= 1'b0;
      crossing     <= 1'b0;
      k            <= 5'd0;
      best_k       <= 5'd0;
      best_d       <= 24'd0;
      o_note       <= 5'd0;
      o_note_valid <= 1'b0;
      o_note_hit   <= 1'b0;
      o_timeout    <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_note_valid <= 1'b0;
      o_timeout    <= 1'b0;
      case (state)
        IDLE: begin
          arm      <= arm_next;
          crossing <= crossing_next;
          if (crossing) begin
            cnt   <= {11'd0, i_sample_valid};
            xcnt  <= '0;
            state <= MEASURE;
          end
        end

        MEASURE: begin
          if (crossing && (xcnt == X_LAST)) begin
            // cnt freezes here; samples from now until IDLE are discarded
            state    <= SEARCH;
            o_busy   <= 1'b1;
            k        <= 5'd0;
            best_k   <= 5'd0;
            best_d   <= '1;
            arm      <= 1'b0;
            crossing <= 1'b0;
          end else if (i_sample_valid && (cnt == CNT_MAX)) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
            arm       <= 1'b0;
            crossing  <= 1'b0;
          end else begin
            arm      <= arm_next;
            crossing <= crossing_next;
            if (crossing)       xcnt <= xcnt + XW'(1);
            if (i_sample_valid) cnt  <= cnt + 12'd1;
          end
        end

        SEARCH: begin
          crossing <= 1'b0;
          if (diff < best_d) begin
            best_k <= k;
            best_d <= diff;
          end
          if (k == K_LAST) begin
            state <= DONE;
          end else begin
            k <= k + 5'd1;
          end
        end

        default: begin
          crossing     <= 1'b0;
          o_note       <= best_k;
          o_note_hit   <= (best_d <= TOL);
          o_note_valid <= 1'b1;
          o_busy       <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_note_detector.sv
// ============================================================================
// tb_note_detector : directed tone, timeout, hysteresis and reset vectors
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample;
  logic [4:0]  note;
  logic        note_valid;
  logic        note_hit;
  logic        timeout;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  int cyc        = 0;
  int nv_count   = 0;
  int nv_cyc     = 0;
  int to_count   = 0;
  int to_cyc     = 0;
  int overlap    = 0;
  int busy_count = 0;

  int t_last  = 0;
  int t_final = 0;

  note_detector dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_sample_valid (sample_valid),
    .i_sample       (sample),
    .o_note         (note),
    .o_note_valid   (note_valid),
    .o_note_hit     (note_hit),
    .o_timeout      (timeout),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (note_valid) begin
      nv_count = nv_count + 1;
      nv_cyc   = cyc;
    end
    if (timeout) begin
      to_count = to_count + 1;
      to_cyc   = cyc;
    end
    if (note_valid && timeout) overlap = overlap + 1;
    if (busy) busy_count = busy_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One strobed sample every 4 clocks, entered at a falling edge.
  task automatic send(input logic [15:0] v);
    sample       = v;
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    t_last       = cyc;
    sample_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Square wave, low half first, stopping on the 17th rising crossing.
  task automatic play_tone(input int period);
    int low;
    int last;
    low  = period / 2;
    last = low + 16 * period;
    for (int n = 0; n <= last; n++) begin
      send(((n % period) < low) ? -16'sd8000 : 16'sd8000);
    end
    t_final = t_last;
  endtask

  task automatic run_tone(input string tag, input int period, input int exp_note, input int exp_hit);
    int nv0;
    int to0;
    nv0 = nv_count;
    to0 = to_count;
    play_tone(period);
    repeat (40) @(negedge clk);
    check({tag, "_valid_count"}, nv_count - nv0, 1);
    check({tag, "_latency"},     nv_cyc - t_final, 27);
    check({tag, "_note"},        {27'd0, note}, exp_note);
    check({tag, "_hit"},         {31'd0, note_hit}, exp_hit);
    check({tag, "_busy_after"},  {31'd0, busy}, 0);
    check({tag, "_no_timeout"},  to_count - to0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_note"},    {27'd0, note}, 0);
    check({tag, "_hit"},     {31'd0, note_hit}, 0);
    check({tag, "_valid"},   {31'd0, note_valid}, 0);
    check({tag, "_timeout"}, {31'd0, timeout}, 0);
    check({tag, "_busy"},    {31'd0, busy}, 0);
  endtask

  initial begin
    int nv0;
    int to0;
    int b0;

    rst          = 1'b1;
    sample_valid = 1'b0;
    sample       = 16'd0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // cnt 960 -> C5 (P=514560, D=9728)
    run_tone("p60", 60, 0, 1);
    // cnt 480 -> index 12
    run_tone("p30", 30, 12, 1);
    // cnt 240 -> index 24
    run_tone("p15", 15, 24, 1);

    // Reset pulse during SEARCH clears the held note 24 and suppresses the result.
    nv0 = nv_count;
    to0 = to_count;
    play_tone(60);
    repeat (10) @(negedge clk);
    check("search_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_zero_outputs("rst_search");
    repeat (40) @(negedge clk);
    check("rst_search_no_valid",   nv_count - nv0, 0);
    check("rst_search_no_timeout", to_count - to0, 0);
    run_tone("p60_again", 60, 0, 1);

    // cnt 1920 is an octave below the table: nearest is C5 but out of tolerance.
    run_tone("p120", 120, 0, 0);

    // Single crossing, then a flat signal: timeout on the 4096th following sample.
    nv0 = nv_count;
    to0 = to_count;
    send(-16'sd1000);
    send(16'sd1000);
    for (int i = 1; i <= 4095; i++) send(16'sd1000);
    check("timeout_not_early", to_count - to0, 0);
    send(16'sd1000);
    check("timeout_count", to_count - to0, 1);
    check("timeout_cycle", to_cyc - t_last, 0);
    check("timeout_no_valid", nv_count - nv0, 0);
    check("timeout_note_held", {27'd0, note}, 0);

    // Oscillation inside the hysteresis band never arms, so nothing ever fires.
    nv0 = nv_count;
    to0 = to_count;
    b0  = busy_count;
    for (int i = 0; i < 4200; i++) send((i % 2) ? 16'sd200 : -16'sd200);
    repeat (10) @(negedge clk);
    check("hyst_busy", busy_count - b0, 0);
    check("hyst_no_valid", nv_count - nv0, 0);
    check("hyst_no_timeout", to_count - to0, 0);

    check("valid_timeout_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/note_detector.md
NOTE_DETECTOR -- requirements
Module: note_detector

Interface
REQ-001 The module SHALL have the parameter PERIODS, default 16: number of waveform periods accumulated per measurement.
REQ-002 The module SHALL have the parameter HYST, default 16'd256: arming threshold magnitude for zero-crossing detection.
REQ-003 The module SHALL have the parameter REF, default 24'd524288: target product, equal to 32768*PERIODS.
REQ-004 The module SHALL have the parameter TOL, default 24'd15360: maximum accepted |product-REF|, about half a semitone.
REQ-005 The module SHALL have the port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have the port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The module SHALL have the port i_sample_valid, input, 1 bit: strobe marking one 32 kHz audio sample.
REQ-008 The module SHALL have the port i_sample, input, 16 bits: signed two's-complement audio sample.
REQ-009 The module SHALL have the port o_note, output, 5 bits: detected note index 0..24, C5..C7, same indexing as the synth frequency table.
REQ-010 The module SHALL have the port o_note_valid, output, 1 bit: one-cycle pulse when o_note/o_note_hit are updated.
REQ-011 The module SHALL have the port o_note_hit, output, 1 bit: 1 = pitch within TOL of o_note; 0 = out of range.
REQ-012 The module SHALL have the port o_timeout, output, 1 bit: one-cycle pulse when a measurement is aborted.
REQ-013 The module SHALL have the port o_busy, output, 1 bit: high in SEARCH and DONE.

Function
REQ-014 The module SHALL hold an internal 25-entry constant table INC[k] of 12-bit phase increments: 536,568,601,637,675,715,758,803,851,901,955,1011,1072,1135,1203,1274,1350,1430,1515,1606,1701,1802,1909,2023,2143.
REQ-015 The detector SHALL set an arm flag on a valid sample < -HYST, and SHALL register a rising crossing on a valid sample >= 0 while armed, clearing arm on that same sample.
REQ-016 The FSM SHALL have four states, IDLE, MEASURE, SEARCH and DONE, and SHALL reset to IDLE.
REQ-017 In IDLE, on a crossing the FSM SHALL clear the 12-bit sample count cnt, clear the crossing count, and go to MEASURE.
REQ-018 In MEASURE, every valid sample SHALL increment cnt, including the sample that completes a crossing.
REQ-019 In MEASURE, every crossing SHALL increment the crossing count, and the PERIODS-th crossing SHALL move the FSM to SEARCH on the next cycle with cnt frozen.
REQ-020 In MEASURE, a valid sample that would take cnt from 4095 upward SHALL pulse o_timeout for one cycle and return the FSM to IDLE with the arm flag cleared, leaving o_note and o_note_hit unchanged.
REQ-021 SEARCH SHALL take exactly 25 cycles, k = 0..24, one per cycle, computing P = cnt*INC[k] as a 24-bit unsigned value and D = |P - REF|.
REQ-022 SEARCH SHALL keep the best (k, D) pair and replace it only when D is strictly less, so that on ties the lowest index wins.
REQ-023 SEARCH SHALL ignore i_sample_valid; samples arriving during SEARCH and DONE are dropped and do not affect arm state.
REQ-024 DONE SHALL last exactly one cycle, during which the module SHALL register o_note = best k and o_note_hit = (best D <= TOL), pulse o_note_valid, and go to IDLE.
REQ-025 Latency SHALL be 27 clocks from the cycle that registers the final crossing to o_note_valid: 1 transition cycle, 25 SEARCH cycles, and 1 DONE cycle.
REQ-026 o_note and o_note_hit SHALL hold their values between updates.
REQ-027 o_note_valid and o_timeout SHALL never be asserted in the same cycle.
REQ-028 A measurement restart SHALL require a fresh arm and crossing after IDLE is re-entered.

Reset
REQ-029 While i_rst is high at a clock edge, the module SHALL force state=IDLE, cnt=0, crossing count=0, arm=0, best registers=0, o_note=0, o_note_valid=0, o_note_hit=0, o_timeout=0 and o_busy=0.
REQ-030 Reset asserted mid-MEASURE or mid-SEARCH SHALL abort the operation without emitting o_note_valid or o_timeout.
REQ-031 Reset SHALL have priority over all other events in the same cycle.

Verification
REQ-032 A ±8000 square wave with a 60-sample period (30 low, 30 high) SHALL give cnt=960 and o_note_valid with o_note=0, o_note_hit=1 (P=514560, D=9728).
REQ-033 A ±8000 square wave with a 30-sample period SHALL give cnt=480, o_note=12, o_note_hit=1; a 15-sample period SHALL give cnt=240, o_note=24, o_note_hit=1.
REQ-034 A 120-sample period SHALL give cnt=1920, o_note=0, o_note_hit=0.
REQ-035 One crossing followed by a constant +1000 input SHALL give an o_timeout pulse on the 4096th subsequent valid sample with no o_note_valid, and the FSM SHALL return to IDLE.
REQ-036 A ±200 oscillation (below HYST) SHALL never leave IDLE, and o_busy SHALL stay 0.
REQ-037 Asserting i_rst for 1 cycle during SEARCH SHALL force all outputs to 0, with no o_note_valid, and a following 60-sample-period tone SHALL again report o_note=0, o_note_hit=1.
